// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one instruction-memory request
// in flight and hands one instruction at a time to decode over a valid/ready handshake.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          PREFETCH = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    output logic [31:0] ins,
    output logic        insValid,
    input  logic        insReady,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    input  logic        jump,
    input  logic        jumpReg,
    input  logic        branchTaken,
    input  logic [31:0] regTarget
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        VALID,
        SPEC,
        FULL,
        DRAIN
    } fetchStateT;

    fetchStateT  state;
    fetchStateT  stateNext;
    logic [31:0] fetchAddr;
    logic [31:0] fetchAddrNext;
    logic [31:0] drainTarget;
    logic [31:0] drainTargetNext;
    logic [31:0] pbuf;
    logic [31:0] pbufNext;
    logic [31:0] insNext;
    logic [31:0] pcNext;
    logic        insValidNext;
    logic        reqRaw;
    logic [31:0] addrRaw;
    logic        transfer;
    logic        redirect;
    logic [31:0] branchOffset;
    logic [31:0] target;

    assign pcPlus4      = pc + 32'd4;
    assign transfer     = insValid & insReady;
    assign redirect     = transfer & (jumpReg | jump | branchTaken);
    assign branchOffset = {{14{ins[15]}}, ins[15:0], 2'b00};

    // Without any redirect the target collapses to pcPlus4, so every transfer can issue 'target'.
    always_comb begin
        if (jumpReg) begin
            target = regTarget;
        end else if (jump) begin
            target = {pcPlus4[31:28], ins[25:0], 2'b00};
        end else if (branchTaken) begin
            target = pcPlus4 + branchOffset;
        end else begin
            target = pcPlus4;
        end
    end

    always_comb begin
        stateNext       = state;
        fetchAddrNext   = fetchAddr;
        drainTargetNext = drainTarget;
        pbufNext        = pbuf;
        insNext         = ins;
        pcNext          = pc;
        insValidNext    = insValid;
        reqRaw          = 1'b0;
        addrRaw         = fetchAddr;

        case (state)
            IDLE: begin
                reqRaw    = 1'b1;
                addrRaw   = fetchAddr;
                stateNext = WAIT;
            end
            WAIT: begin
                if (imemRvalid) begin
                    insNext      = imemRdata;
                    pcNext       = fetchAddr;
                    insValidNext = 1'b1;
                    stateNext    = VALID;
                end
            end
            VALID: begin
                if (transfer) begin
                    reqRaw        = 1'b1;
                    addrRaw       = target;
                    fetchAddrNext = target;
                    insValidNext  = 1'b0;
                    stateNext     = WAIT;
                end else if (PREFETCH) begin
                    reqRaw        = 1'b1;
                    addrRaw       = pcPlus4;
                    fetchAddrNext = pcPlus4;
                    stateNext     = SPEC;
                end
            end
            SPEC: begin
                if (imemRvalid) begin
                    if (!transfer) begin
                        pbufNext  = imemRdata;
                        stateNext = FULL;
                    end else if (!redirect) begin
                        insNext   = imemRdata;
                        pcNext    = pcPlus4;
                        stateNext = VALID;
                    end else begin
                        reqRaw        = 1'b1;
                        addrRaw       = target;
                        fetchAddrNext = target;
                        insValidNext  = 1'b0;
                        stateNext     = WAIT;
                    end
                end else if (transfer) begin
                    // The in-flight prefetch is either the wanted word or must be drained first.
                    insValidNext = 1'b0;
                    if (!redirect) begin
                        fetchAddrNext = pcPlus4;
                        stateNext     = WAIT;
                    end else begin
                        drainTargetNext = target;
                        stateNext       = DRAIN;
                    end
                end
            end
            FULL: begin
                if (transfer) begin
                    if (!redirect) begin
                        insNext   = pbuf;
                        pcNext    = pcPlus4;
                        stateNext = VALID;
                    end else begin
                        reqRaw        = 1'b1;
                        addrRaw       = target;
                        fetchAddrNext = target;
                        insValidNext  = 1'b0;
                        stateNext     = WAIT;
                    end
                end
            end
            DRAIN: begin
                if (imemRvalid) begin
                    reqRaw        = 1'b1;
                    addrRaw       = drainTarget;
                    fetchAddrNext = drainTarget;
                    stateNext     = WAIT;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Requests are suppressed while reset is asserted even though IDLE would otherwise request.
    assign imemReq  = reqRaw & reset_n;
    assign imemAddr = addrRaw;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            fetchAddr   <= RESET_PC;
            drainTarget <= RESET_PC;
            pbuf        <= 32'h0;
            ins         <= 32'h0;
            pc          <= RESET_PC;
            insValid    <= 1'b0;
        end else begin
            state       <= stateNext;
            fetchAddr   <= fetchAddrNext;
            drainTarget <= drainTargetNext;
            pbuf        <= pbufNext;
            ins         <= insNext;
            pc          <= pcNext;
            insValid    <= insValidNext;
        end
    end

endmodule
